// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed restoring divider, Z = {remainder, quotient}
// Quotient truncates toward zero; remainder follows the dividend's sign.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] Z
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
    logic qneg_q, qneg_d, rneg_q, rneg_d, done_q, done_d, dbz_q, dbz_d;
    logic [2*WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0] shifted, trial;
    assign abs_a = A[WIDTH-1] ? -A : A;
    assign abs_b = B[WIDTH-1] ? -B : B;
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign trial = shifted - {1'b0, dvs_q};
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign div_by_zero = dbz_q;
    assign Z = z_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        rem_d = rem_q;
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        done_d = 1'b0;
        dbz_d = dbz_q;
        z_d = z_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = (B == '0) ? ZERO : RUN;
                qneg_d = A[WIDTH-1] ^ B[WIDTH-1];
                rneg_d = A[WIDTH-1];
                // a zero divisor keeps the raw dividend so it can be returned as the remainder
                dvd_d = (B == '0) ? A : abs_a;
                dvs_d = abs_b;
                rem_d = '0;
                cnt_d = '0;
                dbz_d = 1'b0;
            end
            RUN: begin
                rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : RUN;
            end
            FIX: begin
                z_d = {rneg_q ? -rem_q : rem_q, qneg_q ? -dvd_q : dvd_q};
                done_d = 1'b1;
                state_d = IDLE;
            end
            ZERO: begin
                z_d = {dvd_q, {WIDTH{1'b1}}};
                done_d = 1'b1;
                dbz_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q <= '0;
            rem_q <= '0;
            dvd_q <= '0;
            dvs_q <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q <= 1'b0;
            z_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            done_q <= done_d;
            dbz_q <= dbz_d;
            z_q <= z_d;
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider
// Stimulus pushes expected {Z, div_by_zero, done cycle}; the monitor pops on done.
module tb_seq_divider;
    logic clk = 1'b0, clear = 1'b1, start = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic busy, done, div_by_zero;
    logic [63:0] Z;
    int total = 0, bad = 0, cyc = 0;

    typedef struct {
        logic [63:0] z;
        logic        dbz;
        int          at;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    seq_divider #(.WIDTH(32)) dut (
        .clk(clk), .clear(clear), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .Z(Z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done cycle=%0d Z=%h", cyc, Z);
            end else begin
                mon_e = sb.pop_front();
                total += 4;
                if (Z !== mon_e.z) begin bad++; $display("FAIL z got=%h exp=%h", Z, mon_e.z); end
                if (div_by_zero !== mon_e.dbz) begin bad++; $display("FAIL dbz got=%b exp=%b", div_by_zero, mon_e.dbz); end
                if (cyc != mon_e.at) begin bad++; $display("FAIL latency done_cycle=%0d exp=%0d", cyc, mon_e.at); end
                if (busy !== 1'b0) begin bad++; $display("FAIL busy_in_done got=%b exp=0", busy); end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin bad++; $display("FAIL %s got=%h exp=%h", name, got, exp); end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] ez,
                         input logic edbz, input int lat, input bit push);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin @(negedge clk); n++; end
        if (busy) begin total++; bad++; $display("FAIL issue_wait busy=%b exp=0", busy); end
        start = 1'b1; A = a; B = b;
        @(posedge clk);
        #1;
        if (push) sb.push_back('{ez, edbz, cyc + lat});
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    task automatic div(input logic [31:0] a, input logic [31:0] b, input logic [63:0] ez);
        issue(a, b, ez, 1'b0, 33, 1'b1);
    endtask

    initial begin
        int n;
        int sa, sd;
        logic [31:0] ra, rb, q, r;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        check("rst_z", Z, 64'd0);
        clear = 1'b0;

        // start pulses while running must be ignored
        div(32'd100, 32'd7, {32'd2, 32'd14});
        repeat (4) @(negedge clk);
        start = 1'b1; A = 32'd1; B = 32'd0;
        @(negedge clk); start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1; A = 32'd3; B = 32'd3;
        @(negedge clk); start = 1'b0;

        div(-32'sd100, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2});
        div(32'd100, -32'sd7, {32'd2, 32'hFFFFFFF2});
        div(-32'sd100, -32'sd7, {32'hFFFFFFFE, 32'd14});
        div(32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
        div(32'd5, 32'd9, {32'd5, 32'd0});
        issue(32'd42, 32'd0, {32'd42, 32'hFFFFFFFF}, 1'b1, 1, 1'b1);
        repeat (3) @(negedge clk);
        check("dbz_held", {63'd0, div_by_zero}, 64'd1);
        div(32'h80000000, 32'd1, {32'h0, 32'h80000000});
        div(32'h80000000, 32'h80000000, {32'h0, 32'd1});
        div(32'hFFFFFFFF, 32'h80000000, {32'hFFFFFFFF, 32'h0});
        div(32'h7FFFFFFF, 32'd2, {32'd1, 32'h3FFFFFFF});
        issue(-32'sd5, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b1, 1, 1'b1);
        div(32'd0, 32'd5, {32'd0, 32'd0});
        div(32'd7, 32'd7, {32'd0, 32'd1});

        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (rb == 0) rb = 32'd3;
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd5;
            sa = ra; sd = rb;
            q = sa / sd; r = sa % sd;
            div(ra, rb, {r, q});
        end

        // clear mid-run: no done, Z and busy cleared
        issue(32'd1000, 32'd3, 64'd0, 1'b0, 33, 1'b0);
        repeat (9) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        check("clr_busy", {63'd0, busy}, 64'd0);
        check("clr_z", Z, 64'd0);
        clear = 1'b0;
        repeat (40) @(negedge clk);

        div(32'd100, 32'd7, {32'd2, 32'd14});
        n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
